// File: rtl/cmos_capture.sv
// DVP/CMOS sensor capture: pairs RGB565 bytes into 16-bit pixels, skips settling frames, flags aborted frames.
// Latency: pixel strobe two clocks after its second byte is driven; no backpressure (sensor cannot be stalled).
module cmos_capture #(
  parameter int H_ACT      = 1280,
  parameter int V_ACT      = 720,
  parameter int FRAME_SKIP = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmos_vsync,
  input  logic        i_cmos_href,
  input  logic [7:0]  i_cmos_din,
  output logic [15:0] o_dout,
  output logic        o_dout_vld,
  output logic        o_dout_sop,
  output logic        o_dout_eop,
  output logic        o_frame_err
);

  localparam logic [10:0] H_MAX     = 11'(H_ACT);
  localparam logic [9:0]  V_MAX     = 10'(V_ACT);
  localparam logic [10:0] H_LAST    = 11'(H_ACT - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_ACT - 1);
  localparam logic [7:0]  SKIP_LAST = 8'((FRAME_SKIP > 0) ? FRAME_SKIP - 1 : 0);

  typedef enum logic [1:0] {WAIT_VS, SKIP, CAPT} state_t;

  state_t      r_state;
  logic        r_vs1, r_vs2, r_hr1, r_hr2;
  logic [7:0]  r_din1;
  logic [7:0]  r_hi;
  logic [7:0]  r_skip_cnt;
  logic [10:0] r_cnt_x;
  logic [9:0]  r_cnt_y;
  logic        r_toggle;
  logic        r_frame_done;
  logic        r_pix_seen;

  logic w_vs_fall, w_hr_fall, w_pix_done, w_pix_keep, w_sop, w_eop;

  assign w_vs_fall  = r_vs2 & ~r_vs1;
  assign w_hr_fall  = r_hr2 & ~r_hr1;
  assign w_pix_done = (r_state == CAPT) & r_hr1 & ~r_vs1 & r_toggle;
  assign w_pix_keep = w_pix_done & (r_cnt_x < H_MAX) & (r_cnt_y < V_MAX);
  assign w_sop      = (r_cnt_x == 11'd0) & (r_cnt_y == 10'd0);
  assign w_eop      = (r_cnt_x == H_LAST) & (r_cnt_y == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs1  <= 1'b0;
      r_vs2  <= 1'b0;
      r_hr1  <= 1'b0;
      r_hr2  <= 1'b0;
      r_din1 <= 8'd0;
    end else begin
      r_vs1  <= i_cmos_vsync;
      r_vs2  <= r_vs1;
      r_hr1  <= i_cmos_href;
      r_hr2  <= r_hr1;
      r_din1 <= i_cmos_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_VS;
      r_skip_cnt   <= 8'd0;
      r_cnt_x      <= 11'd0;
      r_cnt_y      <= 10'd0;
      r_toggle     <= 1'b0;
      r_hi         <= 8'd0;
      r_frame_done <= 1'b0;
      r_pix_seen   <= 1'b0;
      o_dout       <= 16'd0;
      o_dout_vld   <= 1'b0;
      o_dout_sop   <= 1'b0;
      o_dout_eop   <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_dout_vld  <= 1'b0;
      o_dout_sop  <= 1'b0;
      o_dout_eop  <= 1'b0;
      o_frame_err <= 1'b0;

      case (r_state)
        WAIT_VS: begin
          if (w_vs_fall) r_state <= (FRAME_SKIP > 0) ? SKIP : CAPT;
        end
        SKIP: begin
          if (w_vs_fall) begin
            r_skip_cnt <= r_skip_cnt + 8'd1;
            if (r_skip_cnt == SKIP_LAST) r_state <= CAPT;
          end
        end
        CAPT: ;
        default: r_state <= WAIT_VS;
      endcase

      // Frame start wins over a coincident line end so the new frame begins at row 0.
      if (w_vs_fall) begin
        r_cnt_x      <= 11'd0;
        r_cnt_y      <= 10'd0;
        r_toggle     <= 1'b0;
        r_frame_done <= 1'b0;
        r_pix_seen   <= 1'b0;
        if (r_state == CAPT && !r_frame_done && r_pix_seen) o_frame_err <= 1'b1;
      end else if (r_state == CAPT) begin
        if (r_vs1 || !r_hr1) r_toggle <= 1'b0;
        else                 r_toggle <= ~r_toggle;

        if (r_hr1 && !r_vs1 && !r_toggle) r_hi <= r_din1;

        if (w_pix_done) begin
          if (r_cnt_x != H_MAX) r_cnt_x <= r_cnt_x + 11'd1;
          if (w_pix_keep) begin
            o_dout     <= {r_hi, r_din1};
            o_dout_vld <= 1'b1;
            o_dout_sop <= w_sop;
            o_dout_eop <= w_eop;
            r_pix_seen <= 1'b1;
            if (w_eop) r_frame_done <= 1'b1;
          end
        end

        if (w_hr_fall) begin
          r_cnt_x <= 11'd0;
          if (r_cnt_x != 11'd0 && r_cnt_y != V_MAX) r_cnt_y <= r_cnt_y + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_capture.sv
// Bench for cmos_capture with H_ACT=4, V_ACT=2, FRAME_SKIP=1: table rows, hand sequences and random frames vs a byte-list model.
module tb_cmos_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vs = 1'b0;
  logic        hr = 1'b0;
  logic [7:0]  din = 8'd0;
  logic [15:0] o_dout;
  logic        o_dout_vld, o_dout_sop, o_dout_eop, o_frame_err;

  cmos_capture #(.H_ACT(H), .V_ACT(V), .FRAME_SKIP(FS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cmos_vsync(vs),
    .i_cmos_href (hr),
    .i_cmos_din  (din),
    .o_dout      (o_dout),
    .o_dout_vld  (o_dout_vld),
    .o_dout_sop  (o_dout_sop),
    .o_dout_eop  (o_dout_eop),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic        sop;
    logic        eop;
    int          cyc;
  } pix_t;

  typedef struct {
    int nlines;
    int nbytes;
    int exp_vld;
    int exp_sop;
    int exp_eop;
    int exp_err;
  } row_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   exp_err_q[$];
  int   got_err_q[$];
  int   n_vld, n_sop, n_eop, n_err;
  int   errors = 0;
  int   checks = 0;
  pix_t mon_p;
  row_t tbl[8];

  // Model: vsync falls since reset, and per-frame row / emission bookkeeping.
  int fcount = 0;
  int m_y = 0;
  int m_emit = 0;
  bit m_eop = 1'b0;
  int seq = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_dout_vld) begin
        mon_p.d   = o_dout;
        mon_p.sop = o_dout_sop;
        mon_p.eop = o_dout_eop;
        mon_p.cyc = cyc;
        got_q.push_back(mon_p);
        n_vld++;
        if (o_dout_sop) n_sop++;
        if (o_dout_eop) n_eop++;
      end
      if (o_frame_err) begin
        got_err_q.push_back(cyc);
        n_err++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit capturing();
    return fcount >= FS + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_vs_fall(input int k);
    if (capturing() && m_emit > 0 && !m_eop) exp_err_q.push_back(k + 2);
    fcount++;
    m_y    = 0;
    m_emit = 0;
    m_eop  = 1'b0;
  endtask

  task automatic vsync_pulse();
    step(); hr = 1'b0; vs = 1'b1;
    step(); step(); step();
    vs = 1'b0;
    model_vs_fall(cyc);
    repeat (3) step();
  endtask

  // mode 1 uses the 0x11,0x22,... byte sequence; vs_at >= 0 raises vsync from that byte and ends the frame with href.
  task automatic send_line(input int n, input int mode, input int vs_at);
    logic [7:0] b, hi;
    int   x, npix;
    pix_t p;
    hi = 8'd0;
    npix = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (mode == 1) begin
        seq++;
        b = 8'(seq * 17);
      end else begin
        b = 8'($urandom);
      end
      hr  = 1'b1;
      din = b;
      if (vs_at >= 0 && i >= vs_at) vs = 1'b1;
      if (i % 2 == 0) begin
        hi = b;
      end else if (vs_at < 0 || i < vs_at) begin
        x = i / 2;
        npix++;
        if (capturing() && x < H && m_y < V) begin
          p.d   = {hi, b};
          p.sop = (x == 0 && m_y == 0);
          p.eop = (x == H - 1 && m_y == V - 1);
          p.cyc = cyc + 2;
          exp_q.push_back(p);
          m_emit++;
          if (p.eop) m_eop = 1'b1;
        end
      end
    end
    step();
    hr = 1'b0;
    if (vs_at >= 0 && vs_at < n) begin
      vs = 1'b0;
      model_vs_fall(cyc);
    end else if (npix > 0) begin
      m_y++;
    end
    repeat (3) step();
  endtask

  task automatic compare_queues(input string tag);
    pix_t e, g;
    int   ee, ge;
    check({tag, "_npix"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_dout"}, 32'(g.d), 32'(e.d));
      check({tag, "_sop"},  32'(g.sop), 32'(e.sop));
      check({tag, "_eop"},  32'(g.eop), 32'(e.eop));
      check({tag, "_lat"},  32'(g.cyc), 32'(e.cyc));
    end
    check({tag, "_nerr"}, 32'(got_err_q.size()), 32'(exp_err_q.size()));
    while (exp_err_q.size() > 0 && got_err_q.size() > 0) begin
      ee = exp_err_q.pop_front();
      ge = got_err_q.pop_front();
      check({tag, "_errcyc"}, 32'(ge), 32'(ee));
    end
    exp_q.delete();
    got_q.delete();
    exp_err_q.delete();
    got_err_q.delete();
  endtask

  task automatic clear_counts();
    n_vld = 0; n_sop = 0; n_eop = 0; n_err = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"}, 32'(o_dout), 32'd0);
    check({tag, "_vld"},  32'(o_dout_vld), 32'd0);
    check({tag, "_sop"},  32'(o_dout_sop), 32'd0);
    check({tag, "_eop"},  32'(o_dout_eop), 32'd0);
    check({tag, "_err"},  32'(o_frame_err), 32'd0);
  endtask

  initial begin
    tbl[0] = '{2,  8, 8, 1, 1, 0};
    tbl[1] = '{3, 12, 8, 1, 1, 0};
    tbl[2] = '{1,  8, 4, 1, 0, 1};
    tbl[3] = '{2,  9, 8, 1, 1, 0};
    tbl[4] = '{2,  6, 6, 1, 0, 1};
    tbl[5] = '{2,  1, 0, 0, 0, 0};
    tbl[6] = '{2,  7, 6, 1, 0, 1};
    tbl[7] = '{3,  8, 8, 1, 1, 0};

    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();

    // First frame after reset is discarded, the second is captured.
    clear_counts();
    seq = 0;
    vsync_pulse();
    send_line(8, 1, -1);
    send_line(8, 1, -1);
    check("skip_vld", 32'(n_vld), 32'd0);
    seq = 0;
    vsync_pulse();
    send_line(8, 1, -1);
    send_line(8, 1, -1);
    if (got_q.size() > 0) begin
      check("first_dout", 32'(got_q[0].d), 32'h1122);
      check("first_sop", 32'(got_q[0].sop), 32'd1);
    end else begin
      check("first_present", 32'd0, 32'd1);
    end
    vsync_pulse();
    check("f2_vld", 32'(n_vld), 32'd8);
    check("f2_sop", 32'(n_sop), 32'd1);
    check("f2_eop", 32'(n_eop), 32'd1);
    check("f2_err", 32'(n_err), 32'd0);
    compare_queues("f2");

    for (int r = 0; r < 8; r++) begin
      clear_counts();
      for (int l = 0; l < tbl[r].nlines; l++) send_line(tbl[r].nbytes, 0, -1);
      vsync_pulse();
      check("tbl_vld", 32'(n_vld), 32'(tbl[r].exp_vld));
      check("tbl_sop", 32'(n_sop), 32'(tbl[r].exp_sop));
      check("tbl_eop", 32'(n_eop), 32'(tbl[r].exp_eop));
      check("tbl_err", 32'(n_err), 32'(tbl[r].exp_err));
      compare_queues("tbl");
    end

    // vsync rises mid-line, then href and vsync fall together; next frame must restart at row 0.
    clear_counts();
    send_line(8, 0, 4);
    check("vsmid_vld", 32'(n_vld), 32'd2);
    check("vsmid_err", 32'(n_err), 32'd1);
    send_line(8, 0, -1);
    send_line(8, 0, -1);
    vsync_pulse();
    compare_queues("vsmid");

    for (int f = 0; f < 20; f++) begin
      int nl;
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) send_line($urandom_range(0, 11), 0, -1);
      if ($urandom_range(0, 3) == 0) send_line(6, 0, $urandom_range(0, 5));
      else vsync_pulse();
      compare_queues("rand");
    end

    // Reset in the middle of a pixel.
    vsync_pulse();
    seq = 0;
    send_line(8, 1, -1);
    compare_queues("prerst");
    check("hold_dout", 32'(o_dout), 32'h7788);
    step(); hr = 1'b1; din = 8'hA5;
    step(); din = 8'h5A;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("asyncrst");
    hr = 1'b0;
    repeat (3) step();
    check_outputs_zero("heldrst");
    rst_n = 1'b1;
    fcount = 0; m_y = 0; m_emit = 0; m_eop = 1'b0;
    exp_q.delete(); got_q.delete(); exp_err_q.delete(); got_err_q.delete();
    repeat (2) step();
    clear_counts();
    vsync_pulse();
    send_line(8, 0, -1);
    send_line(8, 0, -1);
    check("rst_skip_vld", 32'(n_vld), 32'd0);
    vsync_pulse();
    send_line(8, 0, -1);
    send_line(8, 0, -1);
    vsync_pulse();
    check("rst_cap_vld", 32'(n_vld), 32'd8);
    compare_queues("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmos_capture.md
CMOS_CAPTURE -- requirements
Module: cmos_capture

Interface
REQ-001 Parameter H_ACT, default 1280, active pixels per line.
REQ-002 Parameter V_ACT, default 720, active lines per frame.
REQ-003 Parameter FRAME_SKIP, default 10, whole frames discarded after reset (sensor settling); legal range 0..255.
REQ-004 clk  input  1  pixel clock from sensor (PCLK); all logic on its rising edge; one clock domain only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmos_vsync  input  1  frame sync, active high; its falling edge marks frame start.
REQ-007 cmos_href  input  1  line valid, active high.
REQ-008 cmos_din  input  8  sensor data byte, RGB565, high byte first.
REQ-009 dout  output  16  assembled pixel {first byte, second byte}.
REQ-010 dout_vld  output  1  one-cycle strobe, dout valid.
REQ-011 dout_sop  output  1  high with dout_vld on pixel (0,0) of a frame.
REQ-012 dout_eop  output  1  high with dout_vld on pixel (H_ACT-1,V_ACT-1).
REQ-013 frame_err  output  1  one-cycle pulse on frame abort or short frame.

Function
REQ-014 cmos_vsync, cmos_href, cmos_din SHALL be registered once (stage 1); vsync additionally delayed to stage 2; vsync_fall = stage2 & ~stage1.
REQ-015 FSM states WAIT_VS, SKIP, CAPT; reset state WAIT_VS.
REQ-016 WAIT_VS: on vsync_fall -> SKIP if FRAME_SKIP>0, else CAPT.
REQ-017 SKIP: skip_cnt (8 bit) increments on each vsync_fall; on vsync_fall with skip_cnt==FRAME_SKIP-1 -> CAPT; exactly FRAME_SKIP frames discarded; no outputs asserted in SKIP or WAIT_VS.
REQ-018 CAPT is terminal; only reset leaves it.
REQ-019 Byte toggle: in CAPT, each cycle with stage-1 href high flips toggle; toggle 0 latches byte as dout[15:8], toggle 1 completes pixel.
REQ-020 Toggle SHALL clear when stage-1 href low; a dangling odd byte at line end is discarded, no strobe.
REQ-021 Latency: second byte present on cmos_din at edge k -> dout/dout_vld registered at edge k+2, held one cycle.
REQ-022 cnt_x (11 bit) increments per completed pixel, clears on href falling edge (stage 1) and on vsync_fall.
REQ-023 cnt_y (10 bit) increments on href falling edge when cnt_x>0, clears on vsync_fall.
REQ-024 Pixels with cnt_x>=H_ACT or lines with cnt_y>=V_ACT SHALL be dropped (no dout_vld); counters saturate, no wrap.
REQ-025 dout_sop = dout_vld & cnt_x==0 & cnt_y==0; dout_eop = dout_vld & cnt_x==H_ACT-1 & cnt_y==V_ACT-1.
REQ-026 frame_done flag sets on dout_eop, clears on vsync_fall.
REQ-027 In CAPT, vsync_fall with frame_done==0 and at least one pixel emitted since previous vsync_fall SHALL pulse frame_err for one cycle; the new frame captures normally.
REQ-028 vsync rising mid-line SHALL stop output immediately (stage-1 vsync high gates dout_vld) and clear toggle.
REQ-029 Simultaneous href falling and vsync_fall: vsync_fall clear takes priority; cnt_y = 0.
REQ-030 dout retains last value when dout_vld low.

Reset
REQ-031 rst_n low SHALL asynchronously clear: all outputs to 0, FSM to WAIT_VS, skip_cnt, cnt_x, cnt_y, toggle, frame_done, and all input pipeline registers.
REQ-032 Reset asserted mid-frame SHALL discard partial pixel; after release capture restarts from WAIT_VS, including full FRAME_SKIP.

Verification (bench uses H_ACT=4, V_ACT=2, FRAME_SKIP=1)
REQ-033 Skip: two frames of bytes 0x11,0x22,... -> frame 1 produces no dout_vld; frame 2 produces 8 strobes, first dout=0x1122 with sop=1.
REQ-034 Framing: frame 2 -> exactly one sop (pixel 0) and one eop (8th strobe), dout_vld 2 cycles after each second byte, frame_err=0.
REQ-035 Odd line: 9 bytes on one href -> 4 pixels, 9th byte dropped, next line starts dout[15:8]=its first byte.
REQ-036 Overlength: 6 pixels per line, 3 lines -> only 4x2 strobes, eop on line 2 pixel 3, no counter wrap.
REQ-037 Short frame: vsync pulse after 1 line in CAPT -> frame_err pulses 1 cycle, next frame sop=1 on first pixel.
REQ-038 Reset mid-line in CAPT -> outputs 0 asynchronously; after release first frame again skipped.
